// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: opcode classes, load-queue entry and load data extension.
// Define WB_SIGN_EXT_EN to enable the signed-byte and halfword loads.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int LQ_RD_W   = 4;

    localparam logic [4:0] OP_LOAD   = 5'b10000;
    localparam logic [4:0] OP_STORE  = 5'b10001;
    localparam logic [4:0] OP_LOADB  = 5'b10010;
    localparam logic [4:0] OP_CMP    = 5'b01010;
`ifdef WB_SIGN_EXT_EN
    localparam logic [4:0] OP_LOADSB = 5'b10011;
    localparam logic [4:0] OP_LOADH  = 5'b10100;
`endif

    typedef struct packed {
        logic [LQ_RD_W-1:0] rd;
        logic               byte_ld;
`ifdef WB_SIGN_EXT_EN
        logic               sign;
        logic               half;
`endif
    } lq_entry_t;

    function automatic logic [WB_DATA_W-1:0] ext_load(lq_entry_t e, logic [WB_DATA_W-1:0] d);
        logic [WB_DATA_W-1:0] r;
        r = d;
`ifdef WB_SIGN_EXT_EN
        if (e.half)
            r = {{(WB_DATA_W-16){1'b0}}, d[15:0]};
        else if (e.byte_ld)
            r = {{(WB_DATA_W-8){e.sign & d[7]}}, d[7:0]};
`else
        if (e.byte_ld)
            r = {{(WB_DATA_W-8){1'b0}}, d[7:0]};
`endif
        return r;
    endfunction

endpackage

// File: rtl/wb_load_queue.sv
// In-order outstanding-load FIFO; every slot and its valid bit are exposed so the
// parent can build the pending-load scoreboard. DEPTH must be a power of two.
module wb_load_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  lq_entry_t              push_entry_i,
    input  logic                   pop_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [CW-1:0]          count_o,
    output lq_entry_t              head_o,
    output lq_entry_t [DEPTH-1:0]  entries_o,
    output logic [DEPTH-1:0]       valid_o
);

    logic [PW-1:0]          wptr_q, rptr_q;
    logic [CW-1:0]          count_q;
    lq_entry_t [DEPTH-1:0]  mem_q;
    logic [DEPTH-1:0]       vld_q;
    logic                   do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            mem_q   <= '0;
            vld_q   <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= push_entry_i;
                vld_q[wptr_q] <= 1'b1;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (do_pop) begin
                vld_q[rptr_q] <= 1'b0;
                rptr_q        <= rptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o   = count_q;
    assign head_o    = mem_q[rptr_q];
    assign entries_o = mem_q;
    assign valid_o   = vld_q;

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback stage: picks ALU result or returning load data for the single register-file
// write port, tracks outstanding loads in order. WB_SIGN_EXT_EN adds LOADSB/LOADH.
module reg_writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int OPC_W      = 5,
    parameter int LQ_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OPC_W-1:0]            in_opcode,
    input  logic                        in_cond_pass,
    input  logic [REG_ADDR_W-1:0]       in_rd,
    input  logic [DATA_W-1:0]           in_alu_result,
    input  logic                        mem_rvalid,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        rf_we,
    output logic [REG_ADDR_W-1:0]       rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
    output logic [2**REG_ADDR_W-1:0]    load_pending,
    output logic [$clog2(LQ_DEPTH):0]   lq_count,
    output logic                        proto_err
);

    lq_entry_t                lq_push_ent, lq_head;
    lq_entry_t [LQ_DEPTH-1:0] lq_ent;
    logic [LQ_DEPTH-1:0]      lq_vld;
    logic                     lq_full, lq_empty;
    logic                     accept, is_load, no_write, push, pop, alu_wr;

    logic                     rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0]    rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]        rf_wdata_q, rf_wdata_d;
    logic                     proto_err_q, proto_err_d;

    // Memory return owns the write port, so a return stalls issue for that cycle.
    assign in_ready = !mem_rvalid && !lq_full;
    assign accept   = in_valid && in_ready;

    always_comb begin
        is_load     = 1'b0;
        lq_push_ent = '0;
        lq_push_ent.rd = LQ_RD_W'(in_rd);
        case (in_opcode)
            OP_LOAD:   is_load = 1'b1;
            OP_LOADB:  begin is_load = 1'b1; lq_push_ent.byte_ld = 1'b1; end
`ifdef WB_SIGN_EXT_EN
            OP_LOADSB: begin is_load = 1'b1; lq_push_ent.byte_ld = 1'b1; lq_push_ent.sign = 1'b1; end
            OP_LOADH:  begin is_load = 1'b1; lq_push_ent.half = 1'b1; end
`endif
            default:   is_load = 1'b0;
        endcase
    end

    assign no_write = (in_opcode == OP_STORE) || (in_opcode == OP_CMP);
    assign push     = accept && in_cond_pass && is_load;
    assign alu_wr   = accept && in_cond_pass && !is_load && !no_write;
    assign pop      = mem_rvalid && !lq_empty;

    wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (lq_push_ent),
        .pop_i        (pop),
        .full_o       (lq_full),
        .empty_o      (lq_empty),
        .count_o      (lq_count),
        .head_o       (lq_head),
        .entries_o    (lq_ent),
        .valid_o      (lq_vld)
    );

    always_comb begin
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        proto_err_d = proto_err_q | (mem_rvalid && lq_empty);
        if (pop) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = REG_ADDR_W'(lq_head.rd);
            rf_wdata_d = DATA_W'(ext_load(lq_head, WB_DATA_W'(mem_rdata)));
        end else if (alu_wr) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = in_rd;
            rf_wdata_d = in_alu_result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        load_pending = '0;
        for (int i = 0; i < LQ_DEPTH; i++)
            if (lq_vld[i]) load_pending[lq_ent[i].rd] = 1'b1;
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit; expected writes are queued at stimulus time
// and checked in order whenever the DUT pulses rf_we.
module tb_reg_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_cond_pass, mem_rvalid;
    logic [4:0]  in_opcode;
    logic [3:0]  in_rd;
    logic [31:0] in_alu_result, mem_rdata;
    logic        rf_we, proto_err;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] load_pending;
    logic [2:0]  lq_count;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    reg_writeback_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_cond_pass(in_cond_pass), .in_rd(in_rd),
        .in_alu_result(in_alu_result), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .load_pending(load_pending), .lq_count(lq_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [3:0] rd, input logic [31:0] res, input logic cp);
        in_valid = 1'b1; in_opcode = op; in_rd = rd; in_alu_result = res; in_cond_pass = cp;
    endtask

    task automatic idle();
        in_valid = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic mret(input logic [31:0] d);
        mem_rvalid = 1'b1; mem_rdata = d;
    endtask

    // Write monitor: every rf_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && rf_we) begin
            if (sb.size() == 0) chk("unexpected_we", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_waddr", {28'd0, rf_waddr}, {28'd0, e.a});
                chk("mon_wdata", rf_wdata, e.d);
            end
        end
    end

    initial begin
        logic [3:0]  rds[4];
        logic [31:0] dat[4];
        logic [15:0] pend_after[4];
        rds = '{4'd1, 4'd2, 4'd2, 4'd7};
        dat = '{32'h11, 32'h22, 32'h33, 32'h77};
        pend_after = '{16'h0084, 16'h0084, 16'h0080, 16'h0000};

        reset = 1'b1; in_valid = 0; in_opcode = 0; in_rd = 0; in_alu_result = 0;
        in_cond_pass = 0; mem_rvalid = 0; mem_rdata = 0;
        @(negedge clk);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_waddr", {28'd0, rf_waddr}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_count", {29'd0, lq_count}, 32'd0);
        chk("rst_pending", {16'd0, load_pending}, 32'd0);
        chk("rst_perr", {31'd0, proto_err}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        reset = 1'b0;
        cyc();

        // ALU write, 1-cycle latency, single pulse
        issue(5'b00100, 4'd3, 32'h0000_00A5, 1'b1);
        sb.push_back('{4'd3, 32'h0000_00A5});
        cyc(); idle();
        chk("alu_we", {31'd0, rf_we}, 32'd1);
        chk("alu_waddr", {28'd0, rf_waddr}, 32'd3);
        chk("alu_wdata", rf_wdata, 32'h0000_00A5);
        cyc();
        chk("alu_we_pulse", {31'd0, rf_we}, 32'd0);

        // Byte load, zero-extended
        issue(5'b10010, 4'd5, 32'hDEAD_BEEF, 1'b1);
        cyc(); idle();
        chk("ldb_no_we", {31'd0, rf_we}, 32'd0);
        chk("ldb_count", {29'd0, lq_count}, 32'd1);
        chk("ldb_pending", {16'd0, load_pending}, 32'h0020);
        cyc(); cyc();
        chk("ldb_pending_hold", {16'd0, load_pending}, 32'h0020);
        mret(32'hFFFF_FF80);
        sb.push_back('{4'd5, 32'h0000_0080});
        #1;
        chk("ldb_ready_ret", {31'd0, in_ready}, 32'd0);
        cyc(); idle();
        chk("ldb_wdata", rf_wdata, 32'h0000_0080);
        chk("ldb_pending_clr", {16'd0, load_pending}, 32'd0);
        chk("ldb_count_clr", {29'd0, lq_count}, 32'd0);

        // Fill queue, then drain in order
        for (int i = 0; i < 4; i++) begin
            issue(5'b10000, rds[i], 32'h0, 1'b1);
            cyc();
        end
        idle();
        chk("full_count", {29'd0, lq_count}, 32'd4);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        chk("full_pending", {16'd0, load_pending}, 32'h0086);
        issue(5'b00100, 4'd8, 32'hBAD0_0008, 1'b1);
        cyc(); idle();
        chk("full_blocked_count", {29'd0, lq_count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            mret(dat[i]);
            sb.push_back('{rds[i], dat[i]});
            cyc();
            chk("drain_pending", {16'd0, load_pending}, {16'd0, pend_after[i]});
            chk("drain_count", {29'd0, lq_count}, 32'(3 - i));
        end
        idle();
        cyc();

        // ALU op coincident with a memory return
        issue(5'b10000, 4'd9, 32'h0, 1'b1);
        cyc();
        issue(5'b00110, 4'd4, 32'h0000_0044, 1'b1);
        mret(32'h0000_0099);
        #1;
        chk("coll_ready", {31'd0, in_ready}, 32'd0);
        sb.push_back('{4'd9, 32'h0000_0099});
        cyc();
        mem_rvalid = 1'b0;
        #1;
        chk("coll_ready_next", {31'd0, in_ready}, 32'd1);
        sb.push_back('{4'd4, 32'h0000_0044});
        chk("coll_first_addr", {28'd0, rf_waddr}, 32'd9);
        cyc(); idle();
        chk("coll_second_addr", {28'd0, rf_waddr}, 32'd4);
        cyc();

        // Suppressed writes and protocol error
        issue(5'b00100, 4'd6, 32'h0000_0666, 1'b0);
        cyc();
        issue(5'b10001, 4'd6, 32'h0000_0667, 1'b1);
        cyc();
        issue(5'b01010, 4'd6, 32'h0000_0668, 1'b1);
        cyc(); idle();
        chk("nw_we", {31'd0, rf_we}, 32'd0);
        chk("nw_count", {29'd0, lq_count}, 32'd0);
        chk("nw_hold_addr", {28'd0, rf_waddr}, 32'd4);
        chk("nw_hold_data", rf_wdata, 32'h0000_0044);
        mret(32'h0000_DEAD);
        cyc(); idle();
        chk("perr_set", {31'd0, proto_err}, 32'd1);
        chk("perr_no_we", {31'd0, rf_we}, 32'd0);
        cyc(); cyc(); cyc();
        chk("perr_sticky", {31'd0, proto_err}, 32'd1);

        // Asynchronous reset with loads outstanding
        issue(5'b10000, 4'd10, 32'h0, 1'b1);
        cyc();
        issue(5'b10010, 4'd11, 32'h0, 1'b1);
        cyc(); idle();
        chk("pre_rst_count", {29'd0, lq_count}, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", {29'd0, lq_count}, 32'd0);
        chk("arst_pending", {16'd0, load_pending}, 32'd0);
        chk("arst_perr", {31'd0, proto_err}, 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        mret(32'h0000_1234);
        cyc(); idle();
        chk("late_ret_perr", {31'd0, proto_err}, 32'd1);
        chk("late_ret_no_we", {31'd0, rf_we}, 32'd0);

`ifdef WB_SIGN_EXT_EN
        issue(5'b10011, 4'd12, 32'h0, 1'b1);
        cyc(); idle();
        mret(32'h0000_0080);
        sb.push_back('{4'd12, 32'hFFFF_FF80});
        cyc(); idle();
        chk("ldsb_wdata", rf_wdata, 32'hFFFF_FF80);
        issue(5'b10100, 4'd13, 32'h0, 1'b1);
        cyc(); idle();
        mret(32'h1234_F00D);
        sb.push_back('{4'd13, 32'h0000_F00D});
        cyc(); idle();
        chk("ldh_wdata", rf_wdata, 32'h0000_F00D);
`else
        issue(5'b10011, 4'd12, 32'h0000_0013, 1'b1);
        sb.push_back('{4'd12, 32'h0000_0013});
        cyc(); idle();
        chk("op13_alu_we", {31'd0, rf_we}, 32'd1);
        chk("op13_count", {29'd0, lq_count}, 32'd0);
        issue(5'b10100, 4'd13, 32'h0000_0014, 1'b1);
        sb.push_back('{4'd13, 32'h0000_0014});
        cyc(); idle();
        chk("op14_alu_wdata", rf_wdata, 32'h0000_0014);
`endif

        cyc(); cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
